// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies one 256-byte page into OAM via $2004.
// The CPU is halted for 2*XFER_LEN+2 cycles; reads/writes alternate so ppu_cs_n always shows a falling edge per byte.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_WE,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] mem_addr,
  output logic        mem_RE,
  input  logic [7:0]  mem_data_in,
  output logic        ppu_cs_n,
  output logic [2:0]  ppu_reg_addr,
  output logic        ppu_WE,
  output logic [7:0]  ppu_data
);

  localparam logic [8:0] LAST_CNT = 9'(XFER_LEN);
  localparam logic [2:0] OAMDATA  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  data_q, data_d;
  logic        trig;

  assign trig = cpu_WE && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      count_q <= 9'd0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    count_d      = count_q;
    data_d       = data_q;
    cpu_rdy      = 1'b0;
    dma_active   = 1'b1;
    mem_addr     = 16'h0000;
    mem_RE       = 1'b0;
    ppu_cs_n     = 1'b1;
    ppu_reg_addr = 3'd0;
    ppu_WE       = 1'b0;
    ppu_data     = data_q;

    case (state_q)
      IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (trig) begin
          page_d  = cpu_data_in;
          count_d = 9'd0;
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = READ;
      end
      READ: begin
        // Page is concatenated, not added: the low byte never carries into the page.
        mem_addr     = {page_q, count_q[7:0]};
        mem_RE       = 1'b1;
        ppu_reg_addr = OAMDATA;
        ppu_WE       = 1'b1;
        state_d      = WRITE;
      end
      WRITE: begin
        ppu_cs_n     = 1'b0;
        ppu_reg_addr = OAMDATA;
        ppu_WE       = 1'b1;
        ppu_data     = mem_data_in;
        data_d       = mem_data_in;
        count_d      = count_q + 9'd1;
        state_d      = ((count_q + 9'd1) == LAST_CNT) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: scoreboard of expected reads/writes per triggered page, plus an OAM model.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        cpu_WE = 1'b0;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] mem_addr;
  logic        mem_RE;
  logic [7:0]  mem_data_in = 8'h00;
  logic        ppu_cs_n;
  logic [2:0]  ppu_reg_addr;
  logic        ppu_WE;
  logic [7:0]  ppu_data;

  oam_dma dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_WE       (cpu_WE),
    .cpu_rdy      (cpu_rdy),
    .dma_active   (dma_active),
    .mem_addr     (mem_addr),
    .mem_RE       (mem_RE),
    .mem_data_in  (mem_data_in),
    .ppu_cs_n     (ppu_cs_n),
    .ppu_reg_addr (ppu_reg_addr),
    .ppu_WE       (ppu_WE),
    .ppu_data     (ppu_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] addr_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  oam [0:255];
  logic [7:0]  oam_ptr = 8'h00;
  logic        prev_cs_n = 1'b1;
  int          wr_cnt = 0;
  int          zero_hits = 0;
  logic [15:0] last_addr = 16'h0000;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h03;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 1-cycle synchronous RAM
  always @(posedge clk) begin
    if (mem_RE) mem_data_in <= mem_val(mem_addr);
  end

  always @(negedge clk) begin
    if (mem_RE) begin
      chk("rd_expected", {31'd0, addr_q.size() != 0}, 1);
      if (addr_q.size() != 0) chk("mem_addr", mem_addr, addr_q.pop_front());
      if (mem_addr == 16'h0000) zero_hits++;
      last_addr = mem_addr;
    end
    if (!ppu_cs_n) begin
      chk("cs_n_single_low", prev_cs_n, 1);
      if (prev_cs_n) begin
        wr_cnt++;
        oam[oam_ptr] = ppu_data;
        oam_ptr = oam_ptr + 8'd1;
        chk("ppu_reg_addr", ppu_reg_addr, 3'd4);
        chk("ppu_WE", ppu_WE, 1);
        chk("wr_expected", {31'd0, data_q.size() != 0}, 1);
        if (data_q.size() != 0) chk("ppu_data", ppu_data, data_q.pop_front());
      end
    end
    prev_cs_n = ppu_cs_n;
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit starts);
    cpu_addr = a;
    cpu_data_in = d;
    cpu_WE = 1'b1;
    if (starts) begin
      for (int i = 0; i < 256; i++) begin
        addr_q.push_back({d, 8'(i)});
        data_q.push_back(mem_val({d, 8'(i)}));
      end
    end
    @(posedge clk); #1;
    cpu_WE = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic run_xfer(input logic [7:0] pg, input bit retrig);
    int n;
    int w0;
    w0 = wr_cnt;
    cpu_write(16'h4014, pg, 1'b1);
    chk("halt_cpu_rdy", cpu_rdy, 0);
    chk("halt_dma_active", dma_active, 1);
    chk("halt_mem_RE", mem_RE, 0);
    chk("halt_cs_n", ppu_cs_n, 1);
    n = 0;
    while (cpu_rdy === 1'b0 && n < 600) begin
      n++;
      if (retrig && n == 40) begin
        cpu_addr = 16'h4014;
        cpu_data_in = 8'h07;
        cpu_WE = 1'b1;
      end else begin
        cpu_WE = 1'b0;
        cpu_addr = 16'h0000;
      end
      @(posedge clk); #1;
    end
    chk("halt_cycles", n, 514);
    chk("cpu_rdy_back", cpu_rdy, 1);
    chk("dma_active_idle", dma_active, 0);
    chk("xfer_writes", wr_cnt - w0, 256);
    chk("addr_q_empty", addr_q.size(), 0);
    chk("data_q_empty", data_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_cpu_rdy", cpu_rdy, 1);
    chk("rst_dma_active", dma_active, 0);
    chk("rst_mem_RE", mem_RE, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_cs_n", ppu_cs_n, 1);
    chk("rst_ppu_WE", ppu_WE, 0);
    chk("rst_reg_addr", ppu_reg_addr, 0);
    chk("rst_ppu_data", ppu_data, 8'h00);

    // Near-miss addresses and a read of the trigger register start nothing
    cpu_write(16'h4013, 8'h01, 1'b0);
    chk("nt_4013_rdy", cpu_rdy, 1);
    cpu_write(16'h4015, 8'h01, 1'b0);
    chk("nt_4015_rdy", cpu_rdy, 1);
    cpu_addr = 16'h4014; cpu_data_in = 8'h09; cpu_WE = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      chk("nt_read_rdy", cpu_rdy, 1);
      chk("nt_read_dma", dma_active, 0);
      @(posedge clk); #1;
    end

    // Page 2 then page 3 back-to-back: second trigger lands in the first IDLE cycle
    run_xfer(8'h02, 1'b0);
    run_xfer(8'h03, 1'b0);
    for (int i = 0; i < 256; i++) chk("oam_pattern", oam[i], 8'(i) ^ 8'h5A);

    zero_hits = 0;
    run_xfer(8'hFF, 1'b0);
    chk("ff_last_addr", last_addr, 16'hFFFF);
    chk("ff_no_zero", zero_hits, 0);

    // $4014 write with 7 mid-transfer must not disturb the page-2 transfer
    run_xfer(8'h02, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("retrig_no_restart", cpu_rdy, 1);
    end

    // Reset at byte 100 WRITE
    w0 = wr_cnt;
    cpu_write(16'h4014, 8'h04, 1'b1);
    repeat (202) begin @(posedge clk); #1; end
    chk("abort_in_write", ppu_cs_n, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_writes", wr_cnt - w0, 101);
    chk("abort_cpu_rdy", cpu_rdy, 1);
    chk("abort_cs_n", ppu_cs_n, 1);
    chk("abort_dma_active", dma_active, 0);
    chk("abort_mem_RE", mem_RE, 0);
    addr_q.delete();
    data_q.delete();
    // Trigger while reset is still asserted is ignored
    cpu_write(16'h4014, 8'h06, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("trig_in_reset_rdy", cpu_rdy, 1);
    chk("trig_in_reset_dma", dma_active, 0);

    run_xfer(8'h05, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
